// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three buses around the unified-memory arbiter: the instruction
//   fetch port (if_*), the load/store port (dm_*), the single-port memory bus
//   (mem_*) and the sticky error flag.
//
//   modport master : arbiter view (takes requests, drives the memory bus)
//   modport slave  : environment view (requesters plus memory)
//
//   if_req/if_addr               fetch request and byte address
//   if_rdata/if_done             fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_be           data request, store select, byte enables
//   dm_addr/dm_wdata             data address and store data
//   dm_rdata/dm_done             load data and one-cycle completion pulse
//   mem_req/mem_we/mem_be        memory request, write enable, byte enables
//   mem_addr/mem_wdata           memory address and write data
//   mem_rdata/mem_ack            memory read data and completion
//   err                          sticky timeout flag
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        output if_rdata, if_done, dm_rdata, dm_done,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        input  if_rdata, if_done, dm_rdata, dm_done,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and
//   load/store (DM). One requester is granted at a time; DM normally wins a
//   tie, but after STARVE_MAX consecutive DM wins over a waiting IF, IF takes
//   priority. Each transaction ends with a one-cycle done pulse, either on
//   mem_ack or on timeout (TIMEOUT cycles without ack, sets sticky err).
//
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : mem_port_arbiter_if.master (request ports, memory bus, err)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.master     bus
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    // Last count value before the abort fires; the grant cycle itself is
    // counted as zero, so mem_req stays high for exactly TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST   = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);
    localparam bit         TMO_EN     = (TIMEOUT != 0);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              dm_done_q, dm_done_d;
    logic              err_q, err_d;
    logic [3:0]        starve_q, starve_d;
    logic [7:0]        tmo_q, tmo_d;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_done_d   = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_done_d   = 1'b0;
        err_d       = err_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;

        case (state_q)
            IDLE: begin
                if (bus.dm_req && !(bus.if_req && starve_q == STARVE_LIM)) begin
                    state_d     = GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_be_d    = bus.dm_be;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    tmo_d       = 8'd0;
                    // Only wins taken from a waiting fetch count toward starvation.
                    if (bus.if_req && starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (bus.if_req) begin
                    state_d     = GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    tmo_d       = 8'd0;
                    starve_d    = 4'd0;
                end
            end

            GNT_IF, GNT_DM: begin
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (state_q == GNT_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        dm_done_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    // Abort: complete the stalled stage with zero data.
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    if (state_q == GNT_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = '0;
                    end
                end else if (TMO_EN) begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_rdata_q  <= '0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= 4'd0;
            tmo_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_done_q   <= if_done_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.err       = err_q;
endmodule
